rra_wrr_apb: RTL and testbench

RRA_WRR_APB -- requirements
Module: rra_wrr_apb

---
 rtl/rra_wrr_apb.sv | 220 ++++++++++++++++++++++
 tb/tb_rra_wrr_apb.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rra_wrr_apb.sv
// Round-robin / weighted round-robin arbiter with APB-style CTRL/STATUS/WEIGHT registers.
// Optional define RRA_TIMEOUT_CNT_EN adds the TOCNT forced-release counter at 0x0C.
module rra_wrr_apb #(
  parameter int NUM_REQ  = 8,
  parameter int WEIGHT_W = 4
) (
  input  logic               Pclk_i,
  input  logic               PReset_i,
  input  logic               PSel_i,
  input  logic               PWrite_i,
  input  logic [7:0]         PAddr_i,
  input  logic [31:0]        PWData_i,
  output logic [31:0]        PRData_o,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_valid_o,
  output logic [4:0]         gnt_id_o
);
  localparam int         LIM_W = (WEIGHT_W > 8) ? WEIGHT_W : 8;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [4:0] LAST  = 5'(NUM_REQ - 1);

  logic [0:0]          state;
  logic                ctrl_en;
  logic                ctrl_mode;
  logic [7:0]          ctrl_timeout;
  logic [WEIGHT_W-1:0] weight [NUM_REQ];
  logic [4:0]          ptr;
  logic [LIM_W-1:0]    hold_cnt;
  logic [NUM_REQ-1:0]  gnt;

  logic wr, rd;
  assign wr = PSel_i && PWrite_i;
  assign rd = PSel_i && !PWrite_i;

  logic       unused_wdata;
  assign unused_wdata = ^PWData_i;

  logic [7:0] woff;
  logic [5:0] widx;
  logic       sel_weight;
  assign woff       = PAddr_i - 8'h10;
  assign widx       = woff[7:2];
  assign sel_weight = (PAddr_i >= 8'h10) && (woff[1:0] == 2'b00) &&
                      ({26'd0, widx} < 32'(NUM_REQ));

  // Two-pass search: first request above ptr, else first request overall (wrap).
  logic               lo_found, hi_found, found;
  logic [4:0]         lo_idx, hi_idx, win;
  logic [NUM_REQ-1:0] win_oh;
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_i[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = 5'(i);
      end
      if (req_i[i] && (5'(i) > ptr) && !hi_found) begin
        hi_found = 1'b1;
        hi_idx   = 5'(i);
      end
    end
    found = lo_found;
    win   = hi_found ? hi_idx : lo_idx;
    win_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      win_oh[i] = (5'(i) == win);
    end
  end

  logic                hold_req;
  logic [WEIGHT_W-1:0] hold_weight;
  logic                other;
  logic [LIM_W-1:0]    limit;
  logic                lim_none;
  logic                at_limit;
  always_comb begin
    hold_req    = 1'b0;
    hold_weight = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (5'(i) == ptr) begin
        hold_req    = req_i[i];
        hold_weight = weight[i];
      end
    end
    other    = found && (win != ptr);
    lim_none = 1'b0;
    if (ctrl_mode) begin
      limit = (hold_weight == '0) ? LIM_W'(1) : LIM_W'(hold_weight);
    end else begin
      limit    = LIM_W'(ctrl_timeout);
      lim_none = (ctrl_timeout == 8'd0);
    end
    // >= keeps a limit lowered mid-grant from being skipped past.
    at_limit = !lim_none && (({1'b0, hold_cnt} + 1'b1) >= {1'b0, limit});
  end

  always_ff @(posedge Pclk_i) begin
    if (PReset_i) begin
      state    <= IDLE;
      gnt      <= '0;
      ptr      <= LAST;
      hold_cnt <= '0;
    end else if (!ctrl_en) begin
      state    <= IDLE;
      gnt      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= GRANT;
            gnt      <= win_oh;
            ptr      <= win;
            hold_cnt <= '0;
          end
        end
        default: begin
          if (!hold_req) begin
            hold_cnt <= '0;
            if (found) begin
              gnt <= win_oh;
              ptr <= win;
            end else begin
              state <= IDLE;
              gnt   <= '0;
            end
          end else if (at_limit) begin
            hold_cnt <= '0;
            if (other) begin
              gnt <= win_oh;
              ptr <= win;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Pclk_i) begin
    if (PReset_i) begin
      ctrl_en      <= 1'b0;
      ctrl_mode    <= 1'b0;
      ctrl_timeout <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        weight[i] <= WEIGHT_W'(1);
      end
    end else if (wr) begin
      if (PAddr_i == 8'h00) begin
        ctrl_en      <= PWData_i[0];
        ctrl_mode    <= PWData_i[1];
        ctrl_timeout <= PWData_i[15:8];
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (sel_weight && (widx == 6'(i))) begin
          weight[i] <= PWData_i[WEIGHT_W-1:0];
        end
      end
    end
  end

  logic [31:0] tocnt_rd;
`ifdef RRA_TIMEOUT_CNT_EN
  logic        forced;
  logic [15:0] tocnt;
  assign forced = ctrl_en && (state == GRANT) && hold_req && at_limit && other;
  always_ff @(posedge Pclk_i) begin
    if (PReset_i) begin
      tocnt <= '0;
    end else if (wr && (PAddr_i == 8'h0C)) begin
      tocnt <= '0;
    end else if (forced && (tocnt != 16'hFFFF)) begin
      tocnt <= tocnt + 16'd1;
    end
  end
  assign tocnt_rd = {16'd0, tocnt};
`else
  assign tocnt_rd = '0;
`endif

  assign gnt_o       = gnt;
  assign gnt_valid_o = |gnt;
  assign gnt_id_o    = gnt_valid_o ? ptr : 5'd0;

  logic [7:0]  popcnt;
  logic [31:0] rdata;
  always_comb begin
    popcnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      popcnt = popcnt + 8'(req_i[i]);
    end
    rdata = '0;
    case (PAddr_i)
      8'h00: rdata = {16'd0, ctrl_timeout, 6'd0, ctrl_mode, ctrl_en};
      8'h04: rdata = {15'd0, gnt_valid_o, 3'd0, gnt_id_o, popcnt};
      8'h0C: rdata = tocnt_rd;
      default: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (sel_weight && (widx == 6'(i))) begin
            rdata = 32'(weight[i]);
          end
        end
      end
    endcase
  end

  always_ff @(posedge Pclk_i) begin
    if (PReset_i) begin
      PRData_o <= '0;
    end else if (rd) begin
      PRData_o <= rdata;
    end
  end
endmodule

// File: tb/tb_rra_wrr_apb.sv
// Directed self-checking bench for rra_wrr_apb (NUM_REQ=8, WEIGHT_W=4).
module tb_rra_wrr_apb;
  logic        clk = 1'b0;
  logic        rst;
  logic        psel;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic [7:0]  req;
  logic [7:0]  gnt;
  logic        gvalid;
  logic [4:0]  gid;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] rd;
  logic [31:0] exp_tocnt;

  logic [7:0] exp_b [10] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02};
  logic [7:0] exp_c [7]  = '{8'h02, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01, 8'h02};

  always #5 clk = ~clk;

  rra_wrr_apb #(.NUM_REQ(8), .WEIGHT_W(4)) dut (
    .Pclk_i     (clk),
    .PReset_i   (rst),
    .PSel_i     (psel),
    .PWrite_i   (pwrite),
    .PAddr_i    (paddr),
    .PWData_i   (pwdata),
    .PRData_o   (prdata),
    .req_i      (req),
    .gnt_o      (gnt),
    .gnt_valid_o(gvalid),
    .gnt_id_o   (gid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_gnt(input string tag, input logic [7:0] exp_gnt, input logic [4:0] exp_id);
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".valid"}, 32'(gvalid), 32'(exp_gnt != 8'h00));
    check({tag, ".id"}, 32'(gid), 32'(exp_id));
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d;
    tick();
    psel = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    psel = 1'b1; pwrite = 1'b0; paddr = a;
    tick();
    psel = 1'b0;
    d = prdata;
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; req = '0;
    tick(); tick();
    check_gnt("reset", 8'h00, 5'd0);
    check("reset.prdata", prdata, 32'h0);
    rst = 1'b0;

    // register map after reset
    apb_read(8'h00, rd); check("ctrl_rst", rd, 32'h0);
    apb_read(8'h0C, rd); check("tocnt_rst", rd, 32'h0);
    apb_read(8'h1C, rd); check("weight3_rst", rd, 32'h1);
    tick();
    check("prdata_hold", prdata, 32'h1);
    apb_write(8'h30, 32'hFFFF_FFFF);
    apb_read(8'h30, rd); check("unmapped_w8", rd, 32'h0);
    apb_read(8'h08, rd); check("unmapped_08", rd, 32'h0);

    // plain round-robin, release only on request drop
    req = 8'h05;
    tick(); check_gnt("a.disabled", 8'h00, 5'd0);
    apb_write(8'h00, 32'h0000_0001); check_gnt("a.latency", 8'h00, 5'd0);
    tick(); check_gnt("a.first", 8'h01, 5'd0);
    repeat (3) tick();
    check_gnt("a.hold", 8'h01, 5'd0);
    req = 8'h04; tick(); check_gnt("a.sw1", 8'h04, 5'd2);
    req = 8'h01; tick(); check_gnt("a.sw2", 8'h01, 5'd0);
    req = 8'h00; tick(); check_gnt("a.idle", 8'h00, 5'd0);
    req = 8'h05; tick(); check_gnt("a.rr", 8'h04, 5'd2);

    // timeout 3, two requesters alternate
    req = 8'h00; tick();
    apb_write(8'h00, 32'h0000_0301);
    apb_write(8'h0C, 32'h0);
    req = 8'h03;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("b.seq%0d", i), 32'(gnt), 32'(exp_b[i]));
    end
`ifdef RRA_TIMEOUT_CNT_EN
    exp_tocnt = 32'd3;
`else
    exp_tocnt = 32'd0;
`endif
    apb_read(8'h0C, rd); check("b.tocnt", rd, exp_tocnt);
    check_gnt("b.after_rd", 8'h02, 5'd1);
    apb_write(8'h0C, 32'h0);
    apb_read(8'h0C, rd); check("b.tocnt_clr", rd, 32'h0);
    check_gnt("b.sw", 8'h01, 5'd0);
`ifdef RRA_TIMEOUT_CNT_EN
    exp_tocnt = 32'd1;
`else
    exp_tocnt = 32'd0;
`endif
    apb_read(8'h0C, rd); check("b.tocnt_resume", rd, exp_tocnt);

    // weighted: W0=2, W1=0 (acts as 1)
    req = 8'h00; tick(); check_gnt("c.idle", 8'h00, 5'd0);
    apb_write(8'h10, 32'h2);
    apb_write(8'h14, 32'h0);
    apb_write(8'h00, 32'h0000_0003);
    apb_read(8'h14, rd); check("c.w1", rd, 32'h0);
    apb_read(8'h10, rd); check("c.w0", rd, 32'h2);
    req = 8'h03;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("c.seq%0d", i), 32'(gnt), 32'(exp_c[i]));
    end

    // lone requester keeps grant through its limit
    req = 8'h00; tick();
    apb_write(8'h00, 32'h0000_0201);
    req = 8'h80; tick(); check_gnt("d.first", 8'h80, 5'd7);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("d.keep%0d", i), 32'(gnt), 32'h80);
    end
    apb_read(8'h04, rd); check("d.status", rd, 32'h0001_0701);

    // wrap search, enable clear, ptr preserved across re-enable
    req = 8'h28; tick(); check_gnt("e.wrap", 8'h08, 5'd3);
    apb_write(8'h00, 32'h0000_0200);
    tick(); check_gnt("e.disabled", 8'h00, 5'd0);
    req = 8'hFF;
    apb_write(8'h00, 32'h0000_0001); check_gnt("e.still_idle", 8'h00, 5'd0);
    tick(); check_gnt("e.reenable", 8'h10, 5'd4);
    apb_read(8'h04, rd); check("e.status", rd, 32'h0001_0408);

    // reset mid-grant
    rst = 1'b1; tick();
    check_gnt("f.reset", 8'h00, 5'd0);
    check("f.prdata", prdata, 32'h0);
    rst = 1'b0;
    apb_read(8'h00, rd); check("f.ctrl", rd, 32'h0);
    apb_write(8'h00, 32'h0000_0001);
    tick(); check_gnt("f.lowest", 8'h01, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
